// File: rtl/multi_launch_controller.sv
// Run controller for N_CH parallel compute engines.
// It keeps the engines in reset while idle or armed and enforces a minimum
// reset hold before launch. It then pulses inner_start to the channels latched
// in the mask and collects their done flags until every enabled channel has
// reported. A watchdog can end a run that takes too long, and abort can end a
// run at any time.
//
// Handshake: start and abort are levels, not valid/ready pairs.
//  - start is sampled only in IDLE (to arm) and in ARM (to launch).
//  - done is sampled only in COMPUTE, and only through mask_q.
//  - all_done is a one-cycle pulse with no back-pressure.
//  - inner_start is a one-cycle pulse to each enabled channel, with no
//    back-pressure.
module multi_launch_controller #(
   parameter int N_CH        = 4,
   parameter int INIT_CYCLES = 2,
   parameter int TIMEOUT     = 1024,
   parameter int CNT_W       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [N_CH-1:0] ch_mask,
   input  logic [N_CH-1:0] done,
   output logic [N_CH-1:0] inner_rst,
   output logic [N_CH-1:0] inner_start,
   output logic            busy,
   output logic            all_done,
   output logic            timeout_err,
   output logic [N_CH-1:0] done_status,
   output logic [2:0]      dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_LAUNCH  = 3'd2,
      S_COMPUTE = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   // ARM may exit once hold_cnt reaches INIT_CYCLES-1.
   // With that rule, inner_rst stays asserted for at least INIT_CYCLES cycles.
   localparam logic [CNT_W-1:0] HOLD_MIN = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit               WD_EN    = (TIMEOUT != 0);

   state_t          state_q, state_d;
   logic [N_CH-1:0] mask_q, mask_d;
   logic [N_CH-1:0] status_q, status_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic            terr_q, terr_d;
   logic [N_CH-1:0] status_merged;
   logic            complete;

   // Done flags seen so far, plus the ones arriving this cycle.
   // A done that arrives on the deciding cycle still counts toward completion.
   assign status_merged = status_q | (done & mask_q);
   assign complete      = (status_merged == mask_q);

   // State and run bookkeeping registers; async reset returns everything to idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         status_q <= '0;
         hold_q   <= '0;
         wd_q     <= '0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         status_q <= status_d;
         hold_q   <= hold_d;
         wd_q     <= wd_d;
         terr_q   <= terr_d;
      end
   end

   // Next-state logic: abort overrides everything outside IDLE; completion beats timeout
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      status_d = status_q;
      hold_d   = hold_q;
      wd_d     = wd_q;
      terr_d   = terr_q;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && (ch_mask != '0)) begin
                  state_d  = S_ARM;
                  mask_d   = ch_mask;
                  hold_d   = '0;
                  status_d = '0;
                  terr_d   = 1'b0;
               end
            end
            S_ARM: begin
               if (hold_q != CNT_MAX) begin
                  hold_d = hold_q + CNT_ONE;
               end
               if (!start && (hold_q >= HOLD_MIN)) begin
                  state_d = S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               wd_d    = '0;
               state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
               status_d = status_merged;
               if (wd_q != CNT_MAX) begin
                  wd_d = wd_q + CNT_ONE;
               end
               if (complete) begin
                  state_d = S_FINISH;
               end else if (WD_EN && (wd_q == WD_LAST)) begin
                  terr_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_FINISH: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Output decode from registered state only.
   // Disabled channels stay in reset for the whole run.
   always_comb begin
      inner_rst   = '1;
      inner_start = '0;
      case (state_q)
         S_LAUNCH: begin
            inner_rst   = ~mask_q;
            inner_start = mask_q;
         end
         S_COMPUTE, S_FINISH: begin
            inner_rst = ~mask_q;
         end
         default: begin
            inner_rst = '1;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign all_done    = (state_q == S_FINISH);
   assign timeout_err = terr_q;
   assign done_status = status_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_multi_launch_controller.sv
// Bench for multi_launch_controller: vector table, directed corner sequences,
// then randomized cycles checked against a behavioural model of the run.
module tb_multi_launch_controller;

   localparam int N    = 4;
   localparam int INIT = 2;
   localparam int TO   = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         abort;
   logic [N-1:0] ch_mask;
   logic [N-1:0] done;
   logic [N-1:0] inner_rst;
   logic [N-1:0] inner_start;
   logic         busy;
   logic         all_done;
   logic         timeout_err;
   logic [N-1:0] done_status;
   logic [2:0]   dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [2:0] idle_code;

   multi_launch_controller #(
      .N_CH(N), .INIT_CYCLES(INIT), .TIMEOUT(TO), .CNT_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .ch_mask(ch_mask), .done(done),
      .inner_rst(inner_rst), .inner_start(inner_start), .busy(busy),
      .all_done(all_done), .timeout_err(timeout_err),
      .done_status(done_status), .dbg_state(dbg_state)
   );

   // ---------------- clock/reset block ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // A run is described by where it is: arm_age counts cycles spent armed
   // (-1 = not armed), comp_age counts compute cycles (-1 = not computing),
   // and two flags mark the single launch and finish cycles.
   int           arm_age;
   int           comp_age;
   bit           in_launch;
   bit           in_finish;
   logic [N-1:0] m_mask;
   logic [N-1:0] m_status;
   bit           m_terr;

   function automatic bit model_idle();
      return (arm_age < 0) && !in_launch && (comp_age < 0) && !in_finish;
   endfunction

   task automatic model_reset();
      arm_age   = -1;
      comp_age  = -1;
      in_launch = 1'b0;
      in_finish = 1'b0;
      m_mask    = '0;
      m_status  = '0;
      m_terr    = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit a, input logic [N-1:0] cm,
                             input logic [N-1:0] d);
      if (model_idle()) begin
         if (s && (cm != '0)) begin
            arm_age  = 0;
            m_mask   = cm;
            m_status = '0;
            m_terr   = 1'b0;
         end
      end else if (a) begin
         arm_age   = -1;
         comp_age  = -1;
         in_launch = 1'b0;
         in_finish = 1'b0;
      end else if (arm_age >= 0) begin
         if (!s && (arm_age + 1 >= INIT)) begin
            arm_age   = -1;
            in_launch = 1'b1;
         end else begin
            arm_age++;
         end
      end else if (in_launch) begin
         in_launch = 1'b0;
         comp_age  = 0;
      end else if (comp_age >= 0) begin
         m_status = m_status | (d & m_mask);
         if (m_status == m_mask) begin
            comp_age  = -1;
            in_finish = 1'b1;
         end else if ((TO != 0) && (comp_age + 1 >= TO)) begin
            comp_age = -1;
            m_terr   = 1'b1;
         end else begin
            comp_age++;
         end
      end else begin
         in_finish = 1'b0;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, got, exp);
      end
   endtask

   function automatic logic [15:0] dut_vec();
      return {1'b0, inner_rst, inner_start, busy, all_done, timeout_err, done_status};
   endfunction

   task automatic check_model(input string tag);
      logic [N-1:0] e_rst;
      logic [N-1:0] e_start;
      bit           idle;
      idle    = model_idle();
      e_rst   = (idle || arm_age >= 0) ? {N{1'b1}} : ~m_mask;
      e_start = in_launch ? m_mask : '0;
      chk(tag, dut_vec(),
          {1'b0, e_rst, e_start, !idle, in_finish, m_terr, m_status});
      chk({tag, "_dbg_idle"}, 16'(dbg_state == idle_code), 16'(idle));
   endtask

   // ---------------- driver ----------------
   // Called just after a falling edge: drive, let one rising edge pass, and
   // sample at the following falling edge.
   task automatic cycle(input bit s, input bit a, input logic [N-1:0] cm,
                        input logic [N-1:0] d);
      start   = s;
      abort   = a;
      ch_mask = cm;
      done    = d;
      model_step(s, a, cm, d);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check_model("model");
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit           s;
      bit           a;
      logic [N-1:0] m;
      logic [N-1:0] d;
      logic [N-1:0] e_rst;
      logic [N-1:0] e_start;
      bit           e_busy;
      bit           e_ad;
      bit           e_terr;
      logic [N-1:0] e_ds;
   } vec_t;

   vec_t vecs[20];

   initial begin
      // All channels enabled, done bits staggered.
      vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[1]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[2]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[3]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[4]  = '{1'b0, 1'b0, 4'hF, 4'h1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1};
      vecs[5]  = '{1'b0, 1'b0, 4'hF, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h5};
      vecs[6]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h5};
      vecs[7]  = '{1'b0, 1'b0, 4'hF, 4'hA, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 4'hF};
      vecs[8]  = '{1'b0, 1'b0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF};
      // Mask 0101: unmasked done bits ignored; disabled channels stay in reset.
      vecs[9]  = '{1'b1, 1'b0, 4'h5, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[10] = '{1'b0, 1'b0, 4'h5, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[11] = '{1'b0, 1'b0, 4'h5, 4'h0, 4'hA, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[12] = '{1'b0, 1'b0, 4'h5, 4'h0, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[13] = '{1'b0, 1'b0, 4'h5, 4'hA, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[14] = '{1'b0, 1'b0, 4'h5, 4'hA, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0};
      vecs[15] = '{1'b0, 1'b0, 4'h5, 4'h1, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0, 4'h1};
      vecs[16] = '{1'b0, 1'b0, 4'h5, 4'h4, 4'hA, 4'h0, 1'b1, 1'b1, 1'b0, 4'h5};
      vecs[17] = '{1'b0, 1'b0, 4'h5, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5};
      // start with an empty mask is ignored.
      vecs[18] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5};
      vecs[19] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h5};
   end

   // ---------------- test sequence ----------------
   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      ch_mask = '0;
      done    = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("reset_inner_rst",   16'(inner_rst),   16'hF);
      chk("reset_inner_start", 16'(inner_start), 16'h0);
      chk("reset_busy",        16'(busy),        16'h0);
      chk("reset_all_done",    16'(all_done),    16'h0);
      chk("reset_timeout_err", 16'(timeout_err), 16'h0);
      chk("reset_done_status", 16'(done_status), 16'h0);
      idle_code = dbg_state;
      rst = 1'b0;
      @(negedge clk);

      // Table vectors.
      for (int i = 0; i < 20; i++) begin
         cycle(vecs[i].s, vecs[i].a, vecs[i].m, vecs[i].d);
         chk($sformatf("vec%0d", i), dut_vec(),
             {1'b0, vecs[i].e_rst, vecs[i].e_start, vecs[i].e_busy,
              vecs[i].e_ad, vecs[i].e_terr, vecs[i].e_ds});
      end

      // Watchdog expiry after TO compute cycles with no done.
      cycle(1'b1, 1'b0, 4'hF, 4'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);   // launch
      cycle(1'b0, 1'b0, 4'hF, 4'h0);   // first compute cycle
      for (int i = 0; i < TO - 1; i++) cycle(1'b0, 1'b0, 4'hF, 4'h0);
      chk("wd_still_busy", 16'(busy), 16'h1);
      chk("wd_no_err_yet", 16'(timeout_err), 16'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      chk("wd_busy_low", 16'(busy), 16'h0);
      chk("wd_err_set", 16'(timeout_err), 16'h1);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      chk("wd_err_sticky", 16'(timeout_err), 16'h1);
      cycle(1'b1, 1'b0, 4'hF, 4'h0);
      chk("wd_err_cleared", 16'(timeout_err), 16'h0);
      // Abort while armed.
      cycle(1'b0, 1'b1, 4'hF, 4'h0);
      chk("abort_arm_busy", 16'(busy), 16'h0);
      chk("abort_arm_rst", 16'(inner_rst), 16'hF);

      // Final done on the last watchdog cycle: completion wins.
      cycle(1'b1, 1'b0, 4'h3, 4'h0);
      cycle(1'b0, 1'b0, 4'h3, 4'h0);
      cycle(1'b0, 1'b0, 4'h3, 4'h0);   // launch
      cycle(1'b0, 1'b0, 4'h3, 4'h0);   // first compute cycle
      cycle(1'b0, 1'b0, 4'h3, 4'h1);
      for (int i = 0; i < TO - 2; i++) cycle(1'b0, 1'b0, 4'h3, 4'h0);
      cycle(1'b0, 1'b0, 4'h3, 4'h2);
      chk("edge_all_done", 16'(all_done), 16'h1);
      chk("edge_no_err", 16'(timeout_err), 16'h0);
      chk("edge_status", 16'(done_status), 16'h3);
      cycle(1'b0, 1'b0, 4'h3, 4'h0);

      // Abort in compute, even with every done present.
      cycle(1'b1, 1'b0, 4'hF, 4'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      cycle(1'b0, 1'b1, 4'hF, 4'hF);
      chk("abort_cmp_busy", 16'(busy), 16'h0);
      chk("abort_cmp_ad", 16'(all_done), 16'h0);
      chk("abort_cmp_rst", 16'(inner_rst), 16'hF);
      cycle(1'b1, 1'b0, 4'h0, 4'h0);
      chk("mask0_busy", 16'(busy), 16'h0);

      // start held high 5 cycles; launch one cycle after the fall.
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'hF, 4'h0);
      chk("held_no_pulse", 16'(inner_start), 16'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      chk("held_pulse", 16'(inner_start), 16'hF);
      cycle(1'b0, 1'b0, 4'hF, 4'h0);
      chk("held_pulse_gone", 16'(inner_start), 16'h0);
      cycle(1'b0, 1'b0, 4'hF, 4'h1);
      // Async reset mid-compute.
      start = 1'b0;
      done  = '0;
      rst   = 1'b1;
      #1;
      chk("arst_inner_rst", 16'(inner_rst), 16'hF);
      chk("arst_busy", 16'(busy), 16'h0);
      chk("arst_status", 16'(done_status), 16'h0);
      chk("arst_vec", dut_vec(), 16'h7800);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Randomized cycles against the model.
      for (int i = 0; i < 1500; i++) begin
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
